spi_master_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the SPI master and drives its m_write/m_read/slave_sel/m_data_in controls.
- Accepts byte commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one master transfer per command, waits a fixed transfer time, and optionally reads back m_data_out.
- Returns read-back bytes on a valid/ready response port.

---
 rtl/spi_seq_pkg.sv | 24 ++
 rtl/spi_seq_fifo.sv | 61 ++++++
 rtl/spi_master_sequencer.sv | 144 ++++++++++++++
 tb/tb_spi_master_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and widths for the SPI master command sequencer.
package spi_seq_pkg;

  localparam int SEL_W  = 2;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 1 + SEL_W + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_READ,
    ST_CAPTURE,
    ST_RSP,
    ST_GAP
  } seq_state_t;

  typedef struct packed {
    logic              rd;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Small synchronous command FIFO (DEPTH must be a power of two) with
// asynchronous active-low reset.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     m_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge m_rst) begin
    if (!m_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_sequencer.sv
// Command sequencer driving an SPI master: queues byte commands, issues one
// transfer each and returns read-back bytes. Optional settle gap: SPI_SEQ_GAP_EN.
module spi_master_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int XFER_CYCLES = 18,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              m_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_rd,
  output logic              m_write,
  output logic              m_read,
  output logic [SEL_W-1:0]  slave_sel,
  output logic [DATA_W-1:0] m_data_in,
  input  logic [DATA_W-1:0] m_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic              busy
);

  localparam int CNT_W = $clog2(XFER_CYCLES + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || XFER_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
    $error("spi_master_sequencer: illegal parameter value");
  end

  seq_state_t         state;
  seq_state_t         next_state;
  logic [CNT_W-1:0]   xfer_cnt;
  logic               work_rd;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CMD_W-1:0]   fifo_rd_data;
  cmd_t               head;

  assign head      = cmd_t'(fifo_rd_data);
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  spi_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .m_rst     (m_rst),
    .push      (fifo_push),
    .push_data ({cmd_rd, cmd_sel, cmd_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef SPI_SEQ_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam seq_state_t ST_DONE = ST_GAP;
  logic [GAP_W-1:0] gap_cnt;

  // Preloaded outside GAP so the state lasts exactly GAP_CYCLES cycles.
  always_ff @(posedge clk or negedge m_rst) begin
    if (!m_rst) begin
      gap_cnt <= '0;
    end else if (state != ST_GAP) begin
      gap_cnt <= GAP_W'(GAP_CYCLES - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end
`else
  localparam seq_state_t ST_DONE = ST_IDLE;
`endif

  always_ff @(posedge clk or negedge m_rst) begin
    if (!m_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (!fifo_empty) next_state = ST_LOAD;
      ST_LOAD:    next_state = ST_XFER;
      ST_XFER:    if (xfer_cnt == '0) next_state = work_rd ? ST_READ : ST_DONE;
      ST_READ:    next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_RSP;
      ST_RSP:     if (rsp_ready) next_state = ST_DONE;
`ifdef SPI_SEQ_GAP_EN
      ST_GAP:     if (gap_cnt == '0) next_state = ST_IDLE;
`endif
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    m_write   = (state == ST_LOAD);
    m_read    = (state == ST_READ);
    rsp_valid = (state == ST_RSP);
    fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    busy      = (state != ST_IDLE) || (fifo_count != '0);
  end

  // Master-facing controls change only at a pop and otherwise hold.
  always_ff @(posedge clk or negedge m_rst) begin
    if (!m_rst) begin
      xfer_cnt  <= '0;
      work_rd   <= 1'b0;
      slave_sel <= '0;
      m_data_in <= '0;
      rsp_data  <= '0;
      rsp_sel   <= '0;
    end else begin
      if (state == ST_LOAD) begin
        xfer_cnt <= CNT_W'(XFER_CYCLES - 1);
      end else if (state == ST_XFER && xfer_cnt != '0) begin
        xfer_cnt <= xfer_cnt - CNT_W'(1);
      end
      if (fifo_pop) begin
        work_rd   <= head.rd;
        slave_sel <= head.sel;
        m_data_in <= head.data;
      end
      if (state == ST_CAPTURE) begin
        rsp_data <= m_data_out;
        rsp_sel  <= slave_sel;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Self-checking bench for spi_master_sequencer using a cycle-offset reference
// model; honours SPI_SEQ_GAP_EN when defined.
module tb_spi_master_sequencer;

  localparam int DEPTH = 4;
  localparam int XFER  = 18;
  localparam int GAP   = 2;
`ifdef SPI_SEQ_GAP_EN
  localparam int G_EFF = GAP;
`else
  localparam int G_EFF = 0;
`endif
  localparam int INF = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       m_rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_sel = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_rd = 1'b0;
  logic       m_write;
  logic       m_read;
  logic [1:0] slave_sel;
  logic [7:0] m_data_in;
  logic [7:0] m_data_out = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_sel;
  logic       busy;

  spi_master_sequencer #(
    .DEPTH       (DEPTH),
    .XFER_CYCLES (XFER),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .m_rst      (m_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_data   (cmd_data),
    .cmd_rd     (cmd_rd),
    .m_write    (m_write),
    .m_read     (m_read),
    .slave_sel  (slave_sel),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_sel    (rsp_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rd;
    bit [1:0] sel;
    bit [7:0] data;
  } mcmd_t;

  int       n_assert = 0;
  int       n_fail = 0;
  int       cyc = 0;
  mcmd_t    mq[$];
  int       mw_q[$];
  bit       act = 0;
  bit       a_rd = 0;
  bit [1:0] a_sel = 0;
  int       load_cyc = 0;
  int       idle_from = 0;
  int       rsp_end = 0;
  bit [1:0] e_ssel = 0;
  bit [7:0] e_mdin = 0;
  bit [7:0] e_rdata = 0;
  bit [1:0] e_rsel = 0;
  bit       acc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the outputs of this cycle, drive this cycle's
  // inputs, then advance the reference model across the coming edge.
  task automatic applyStimulus(input bit v, input bit [1:0] s, input bit [7:0] d, input bit r,
                               input bit rr, input bit [7:0] mdo, output bit accepted);
    bit    idle;
    bit    in_rsp;
    bit    can_push;
    mcmd_t head;
    mcmd_t nc;
    @(negedge clk);
    idle = !act || (cyc >= idle_from);
    checkOutput("cmd_ready", cmd_ready, mq.size() < DEPTH);
    checkOutput("m_write", m_write, act && cyc == load_cyc);
    checkOutput("m_read", m_read, act && a_rd && cyc == load_cyc + XFER + 1);
    checkOutput("rsp_valid", rsp_valid, act && a_rd && cyc >= load_cyc + XFER + 3 && cyc < rsp_end);
    checkOutput("busy", busy, !idle || mq.size() != 0);
    checkOutput("slave_sel", slave_sel, e_ssel);
    checkOutput("m_data_in", m_data_in, e_mdin);
    checkOutput("rsp_data", rsp_data, e_rdata);
    checkOutput("rsp_sel", rsp_sel, e_rsel);
    if (m_write === 1'b1) mw_q.push_back(cyc);

    cmd_valid  = v;
    cmd_sel    = s;
    cmd_data   = d;
    cmd_rd     = r;
    rsp_ready  = rr;
    m_data_out = mdo;

    in_rsp = act && a_rd && cyc >= load_cyc + XFER + 3 && cyc < rsp_end;
    if (in_rsp && rr) begin
      rsp_end   = cyc + 1;
      idle_from = cyc + 1 + G_EFF;
    end
    if (act && a_rd && cyc == load_cyc + XFER + 2) begin
      e_rdata = mdo;
      e_rsel  = a_sel;
    end
    can_push = mq.size() < DEPTH;
    if (idle && mq.size() > 0) begin
      head      = mq.pop_front();
      act       = 1;
      load_cyc  = cyc + 1;
      a_rd      = head.rd;
      a_sel     = head.sel;
      e_ssel    = head.sel;
      e_mdin    = head.data;
      rsp_end   = INF;
      idle_from = head.rd ? INF : load_cyc + XFER + 1 + G_EFF;
    end
    accepted = v && can_push;
    if (accepted) begin
      nc.rd = r; nc.sel = s; nc.data = d;
      mq.push_back(nc);
    end
    cyc++;
  endtask

  task automatic resetDut();
    m_rst = 1'b0;
    #1;
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_m_read", m_read, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_slave_sel", slave_sel, 0);
    checkOutput("rst_m_data_in", m_data_in, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_sel", rsp_sel, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    mq.delete();
    act = 0; a_rd = 0; a_sel = 0;
    idle_from = 0; rsp_end = 0;
    e_ssel = 0; e_mdin = 0; e_rdata = 0; e_rsel = 0;
    @(negedge clk);
    m_rst = 1'b1;
    cyc += 2;
  endtask

  initial begin
    int    p;
    int    idx;
    mcmd_t burst[5];

    resetDut();

    // Single write: m_write two cycles after acceptance, no read-back.
    mw_q.delete();
    p = cyc;
    applyStimulus(1, 2'd1, 8'hA5, 0, 0, 8'h00, acc);
    for (int i = 0; i < 28; i++) applyStimulus(0, 0, 0, 0, 0, 8'($urandom), acc);
    checkOutput("p1_mw_count", mw_q.size(), 1);
    checkOutput("p1_mw_lat", (mw_q.size() > 0) ? mw_q[0] - p : -1, 2);

    // Read with master returning 0x5A.
    applyStimulus(1, 2'd0, 8'h3C, 1, 1, 8'h5A, acc);
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 0, 1, 8'h5A, acc);
    checkOutput("p2_rsp_data", rsp_data, 8'h5A);

    // Fill past DEPTH with responses back-pressured for a while.
    burst[0] = '{1, 2'd2, 8'h11};
    burst[1] = '{0, 2'd3, 8'h22};
    burst[2] = '{1, 2'd1, 8'h33};
    burst[3] = '{1, 2'd0, 8'h44};
    burst[4] = '{0, 2'd2, 8'h55};
    idx = 0;
    for (int i = 0; i < 320; i++) begin
      if (idx < 5) begin
        applyStimulus(1, burst[idx].sel, burst[idx].data, burst[idx].rd,
                      (i >= 60) && ($urandom_range(0, 1) == 1), 8'($urandom), acc);
        if (acc) idx++;
      end else begin
        applyStimulus(0, 0, 0, 0, (i >= 60) && ($urandom_range(0, 1) == 1), 8'($urandom), acc);
      end
    end
    checkOutput("p3_all_accepted", idx, 5);

    // Response stall with a write queued behind it.
    mw_q.delete();
    applyStimulus(1, 2'd3, 8'h9E, 1, 0, 8'hC3, acc);
    applyStimulus(1, 2'd1, 8'h0F, 0, 0, 8'hC3, acc);
    for (int i = 0; i < 33; i++) applyStimulus(0, 0, 0, 0, 0, 8'hC3, acc);
    checkOutput("p4_stalled_mw", mw_q.size(), 1);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0, 1, 8'($urandom), acc);
    checkOutput("p4_total_mw", mw_q.size(), 2);

    // Reset in the middle of a transfer.
    applyStimulus(1, 2'd2, 8'h77, 1, 1, 8'h00, acc);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 1, 8'h00, acc);
    resetDut();
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0, 0, 1, 8'($urandom), acc);

    // Two back-to-back writes: pulse spacing includes the optional gap.
    mw_q.delete();
    applyStimulus(1, 2'd1, 8'h01, 0, 1, 8'h00, acc);
    applyStimulus(1, 2'd2, 8'h02, 0, 1, 8'h00, acc);
    for (int i = 0; i < 60; i++) applyStimulus(0, 0, 0, 0, 1, 8'h00, acc);
    checkOutput("p6_mw_count", mw_q.size(), 2);
    checkOutput("p6_mw_spacing", (mw_q.size() > 1) ? mw_q[1] - mw_q[0] : -1, XFER + 2 + G_EFF);

    // Random traffic, then drain.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 2'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 2) != 0, 8'($urandom), acc);
    end
    for (int i = 0; i < 200; i++) applyStimulus(0, 0, 0, 0, 1, 8'($urandom), acc);
    checkOutput("final_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
